// File: rtl/pin_uart_rx_pkg.sv
// Shared types and constants for the pin-name UART receiver.
package pin_uart_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_HIGH,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  localparam logic [7:0] SPACE_CHAR   = 8'h20;
  localparam int         NAME_CHARS   = 4;
  localparam int         MIN_BIT_CLKS = 4;

  // Character counter step: saturates one past a full name so that any
  // overlong name is remembered as "too long" until the next space.
  function automatic logic [2:0] char_cnt_next(input logic [2:0] cnt);
    if (cnt >= 3'(NAME_CHARS + 1)) begin
      return 3'(NAME_CHARS + 1);
    end
    return cnt + 3'd1;
  endfunction

endpackage

// File: rtl/pin_uart_rx_frame.sv
// UART 8N1 frame receiver: optional input synchronizer, start/data/stop
// bit sampling at mid-bit, byte output and framing error pulses.
// Define PIN_UART_RX_SYNC_EN to pass rxd through a 2-flop synchronizer
// (adds 2 cycles of latency); otherwise rxd must already be synchronous.
module pin_uart_rx_frame
  import pin_uart_pkg::*;
#(
  parameter int BIT_CLKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);

  // Bit periods below the minimum cannot place a mid-bit sample, so clamp.
  localparam int CLKS = (BIT_CLKS < MIN_BIT_CLKS) ? MIN_BIT_CLKS : BIT_CLKS;
  localparam int CW   = $clog2(CLKS);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS - 1);

  logic rxd_s;

`ifdef PIN_UART_RX_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  // Two-flop synchronizer, reset to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  assign rxd_s = sync2_q;
`else
  assign rxd_s = rxd;
`endif

  rx_state_e      state_q;
  logic [CW-1:0]  cnt_q;
  logic [3:0]     bit_idx_q;
  logic [7:0]     shreg_q;
  logic [7:0]     byte_data_q;
  logic           byte_valid_q;
  logic           frame_err_q;

  // Frame FSM: the counter counts down to the next mid-bit sample point.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_WAIT_HIGH;
      cnt_q        <= '0;
      bit_idx_q    <= 4'd0;
      shreg_q      <= 8'h00;
      byte_data_q  <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        ST_WAIT_HIGH: begin
          if (rxd_s) begin
            state_q <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (!rxd_s) begin
            state_q <= ST_START;
            cnt_q   <= HALF_LOAD;
          end
        end
        ST_START: begin
          if (cnt_q == '0) begin
            if (rxd_s) begin
              state_q <= ST_IDLE;
            end else begin
              state_q   <= ST_DATA;
              cnt_q     <= FULL_LOAD;
              bit_idx_q <= 4'd0;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt_q == '0) begin
            shreg_q <= {rxd_s, shreg_q[7:1]};
            cnt_q   <= FULL_LOAD;
            if (bit_idx_q == 4'd7) begin
              state_q <= ST_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_STOP: begin
          if (cnt_q == '0) begin
            if (rxd_s) begin
              byte_data_q  <= shreg_q;
              byte_valid_q <= 1'b1;
              state_q      <= ST_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= ST_WAIT_HIGH;
      endcase
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: rtl/pin_uart_rx.sv
// Pin-name beacon receiver: decodes UART bytes and assembles
// space-terminated 4-character pin names.
// Define PIN_UART_RX_SYNC_EN to synchronize rxd inside the frame receiver.
module pin_uart_rx
  import pin_uart_pkg::*;
#(
  parameter int BIT_CLKS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        frame_err,
  output logic [31:0] name,
  output logic        name_valid,
  output logic        name_err,
  output logic        busy
);

  pin_uart_rx_frame #(
    .BIT_CLKS (BIT_CLKS)
  ) u_frame (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  logic [31:0] shift_name_q, shift_name_d;
  logic [31:0] name_q, name_d;
  logic [2:0]  char_cnt_q, char_cnt_d;
  logic        publish;
  logic        reject;

  // Name assembly; publish/reject coincide with the terminating space byte.
  always_comb begin
    shift_name_d = shift_name_q;
    name_d       = name_q;
    char_cnt_d   = char_cnt_q;
    publish      = 1'b0;
    reject       = 1'b0;
    if (byte_valid) begin
      if (byte_data != SPACE_CHAR) begin
        shift_name_d = {shift_name_q[23:0], byte_data};
        char_cnt_d   = char_cnt_next(char_cnt_q);
      end else begin
        if (char_cnt_q == 3'(NAME_CHARS)) begin
          publish = 1'b1;
          name_d  = shift_name_q;
        end else begin
          reject = 1'b1;
        end
        char_cnt_d = 3'd0;
      end
    end else if (frame_err) begin
      char_cnt_d = 3'd0;
    end
  end

  // Name registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_name_q <= 32'h0;
      name_q       <= 32'h0;
      char_cnt_q   <= 3'd0;
    end else begin
      shift_name_q <= shift_name_d;
      name_q       <= name_d;
      char_cnt_q   <= char_cnt_d;
    end
  end

  assign name       = publish ? shift_name_q : name_q;
  assign name_valid = publish;
  assign name_err   = reject;

endmodule

// File: tb/tb_pin_uart_rx.sv
// Directed testbench for pin_uart_rx: one instance at 16 clocks/bit and
// one at 5 clocks/bit, driven with hand-built 8N1 frames.
module tb_pin_uart_rx;

`ifdef PIN_UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd16;
  logic        rxd5;

  logic [7:0]  byte_data16, byte_data5;
  logic        byte_valid16, byte_valid5;
  logic        frame_err16, frame_err5;
  logic [31:0] name16, name5;
  logic        name_valid16, name_valid5;
  logic        name_err16, name_err5;
  logic        busy16, busy5;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int bvCnt16 = 0, feCnt16 = 0, nvCnt16 = 0, neCnt16 = 0, nvOrphan16 = 0, lastNvCyc16 = 0;
  int bvCnt5 = 0, feCnt5 = 0, nvCnt5 = 0, neCnt5 = 0, nvOrphan5 = 0;
  int firstNvCyc5 = 0, lastNvCyc5 = 0;
  logic [7:0] lastByte5 = 8'h00;

  pin_uart_rx #(.BIT_CLKS(16)) dut16 (
    .clk(clk), .rst(rst), .rxd(rxd16),
    .byte_data(byte_data16), .byte_valid(byte_valid16), .frame_err(frame_err16),
    .name(name16), .name_valid(name_valid16), .name_err(name_err16), .busy(busy16)
  );

  pin_uart_rx #(.BIT_CLKS(5)) dut5 (
    .clk(clk), .rst(rst), .rxd(rxd5),
    .byte_data(byte_data5), .byte_valid(byte_valid5), .frame_err(frame_err5),
    .name(name5), .name_valid(name_valid5), .name_err(name_err5), .busy(busy5)
  );

  // Free-running clock and posedge counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor sampling on the falling edge.
  always @(negedge clk) begin
    if (byte_valid16) bvCnt16++;
    if (frame_err16) feCnt16++;
    if (name_err16) neCnt16++;
    if (name_valid16) begin
      nvCnt16++;
      lastNvCyc16 = cyc;
      if (!byte_valid16 || byte_data16 != 8'h20) nvOrphan16++;
    end
    if (byte_valid5) begin
      bvCnt5++;
      lastByte5 = byte_data5;
    end
    if (frame_err5) feCnt5++;
    if (name_err5) neCnt5++;
    if (name_valid5) begin
      if (nvCnt5 == 0) firstNvCyc5 = cyc;
      nvCnt5++;
      lastNvCyc5 = cyc;
      if (!byte_valid5 || byte_data5 != 8'h20) nvOrphan5++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic driveLine(input int which, input logic v);
    if (which == 5) rxd5 = v;
    else rxd16 = v;
  endtask

  // One 8N1 frame; called #1 after a rising edge.
  task automatic applyStimulus(input int which, input logic [7:0] b, input logic stopBit);
    int bc;
    logic [9:0] frame;
    bc = (which == 5) ? 5 : 16;
    frame = {stopBit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      driveLine(which, frame[i]);
      idle(bc);
    end
  endtask

  task automatic sendText(input int which, input string s);
    for (int i = 0; i < s.len(); i++) begin
      applyStimulus(which, s[i], 1'b1);
    end
  endtask

  initial begin
    int n, bv0, fe0, nv0, ne0;
    logic [9:0] fFrame;

    rst = 1'b1;
    rxd16 = 1'b1;
    rxd5 = 1'b1;
    idle(3);
    checkOutput("rst_busy", {31'b0, busy16}, 32'd1);
    checkOutput("rst_name", name16, 32'h0);
    checkOutput("rst_byte", {24'b0, byte_data16}, 32'h0);
    checkOutput("rst_pulses", {29'b0, byte_valid16, name_valid16, name_err16}, 32'h0);
    checkOutput("rst_busy5", {31'b0, busy5}, 32'd1);
    rst = 1'b0;
    idle(5);
    checkOutput("idle_busy", {31'b0, busy16}, 32'd0);

    // Back-to-back "AF12 "
    n = cyc; bv0 = bvCnt16; nv0 = nvCnt16; ne0 = neCnt16; fe0 = feCnt16;
    sendText(16, "AF12 ");
    idle(20);
    checkOutput("af12_bytes", bvCnt16 - bv0, 32'd5);
    checkOutput("af12_nv", nvCnt16 - nv0, 32'd1);
    checkOutput("af12_errs", (neCnt16 - ne0) + (feCnt16 - fe0), 32'd0);
    checkOutput("af12_name", name16, 32'h41463132);
    checkOutput("af12_nv_cycle", lastNvCyc16, n + 793 + SYNC_LAT);

    // Short name then a good one
    nv0 = nvCnt16; ne0 = neCnt16;
    sendText(16, "AF1 ");
    idle(20);
    checkOutput("short_ne", neCnt16 - ne0, 32'd1);
    checkOutput("short_nv", nvCnt16 - nv0, 32'd0);
    checkOutput("short_name", name16, 32'h41463132);
    sendText(16, "B7Q3 ");
    idle(20);
    checkOutput("b7q3_name", name16, 32'h42375133);
    checkOutput("b7q3_nv", nvCnt16 - nv0, 32'd1);

    // Overlong name is rejected
    ne0 = neCnt16;
    sendText(16, "ABCDE ");
    idle(20);
    checkOutput("long_ne", neCnt16 - ne0, 32'd1);
    checkOutput("long_name", name16, 32'h42375133);

    // NUL counts as a character
    applyStimulus(16, 8'h00, 1'b1);
    sendText(16, "ABC ");
    idle(20);
    checkOutput("nul_name", name16, 32'h00414243);

    // Framing error, line held low
    bv0 = bvCnt16; fe0 = feCnt16;
    applyStimulus(16, 8'h41, 1'b0);
    idle(40);
    checkOutput("fe_pulse", feCnt16 - fe0, 32'd1);
    checkOutput("fe_nobyte", bvCnt16 - bv0, 32'd0);
    checkOutput("fe_busy", {31'b0, busy16}, 32'd1);
    rxd16 = 1'b1;
    idle(5);
    checkOutput("fe_recover_busy", {31'b0, busy16}, 32'd0);
    nv0 = nvCnt16;
    sendText(16, "AF12 ");
    idle(20);
    checkOutput("fe_after_name", name16, 32'h41463132);
    checkOutput("fe_after_nv", nvCnt16 - nv0, 32'd1);

    // Short glitch in IDLE
    bv0 = bvCnt16; fe0 = feCnt16;
    rxd16 = 1'b0;
    idle(7);
    rxd16 = 1'b1;
    idle(30);
    checkOutput("glitch_out", (bvCnt16 - bv0) + (feCnt16 - fe0), 32'd0);
    checkOutput("glitch_busy", {31'b0, busy16}, 32'd0);

    // Reset during bit 4 of 'F'
    bv0 = bvCnt16;
    sendText(16, "A");
    fFrame = {1'b1, 8'h46, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rxd16 = fFrame[i];
      idle(16);
    end
    rxd16 = fFrame[5];
    idle(8);
    rst = 1'b1;
    idle(1);
    checkOutput("mid_rst_byte", {24'b0, byte_data16}, 32'h0);
    checkOutput("mid_rst_name", name16, 32'h0);
    checkOutput("mid_rst_busy", {31'b0, busy16}, 32'd1);
    rst = 1'b0;
    rxd16 = 1'b1;
    idle(200);
    checkOutput("mid_rst_nobyte", bvCnt16 - bv0, 32'd1);
    nv0 = nvCnt16;
    sendText(16, "AF12 ");
    idle(20);
    checkOutput("post_rst_name", name16, 32'h41463132);
    checkOutput("post_rst_nv", nvCnt16 - nv0, 32'd1);

    // Fast instance, 10 repeated names
    n = cyc; nv0 = nvCnt5;
    for (int k = 0; k < 10; k++) begin
      sendText(5, "AF12 ");
    end
    idle(20);
    checkOutput("fast_nv", nvCnt5 - nv0, 32'd10);
    checkOutput("fast_first_cycle", firstNvCyc5, n + 248 + SYNC_LAT);
    checkOutput("fast_last_cycle", lastNvCyc5, n + 2498 + SYNC_LAT);
    checkOutput("fast_name", name5, 32'h41463132);
    checkOutput("fast_bytes", bvCnt5, 32'd50);
    checkOutput("fast_last_byte", {24'b0, lastByte5}, 32'h20);
    checkOutput("fast_errs", neCnt5 + feCnt5, 32'd0);
    checkOutput("fast_busy", {31'b0, busy5}, 32'd0);

    checkOutput("nv_align16", nvOrphan16, 32'd0);
    checkOutput("nv_align5", nvOrphan5, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
